fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the SISC CPU: holds the program counter and instruction register, and feeds `opcode`/`mm` to the control FSM. It obeys that FSM's `pc_write`, `pc_sel`, `br_sel`, `pc_rst` and `ir_load` strobes. It tolerates a variable-latency instruction memory via a valid handshake with bounded wait, and detects HLT to freeze fetching.

## Interface
Parameters:
- `PC_W`, 16, program counter / instruction address width.
- `WAIT_LIMIT`, 15, max cycles to wait for `imem_valid` before fetch error; range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_f`  in  1  reset, synchronous, active-low.
- `pc_rst`  in  1  synchronous PC clear from control FSM.
- `pc_write`  in  1  PC update strobe.
- `pc_sel`  in  1  0 = PC+1, 1 = branch target.
- `br_sel`  in  1  1 = absolute target, 0 = PC-relative target.
- `ir_load`  in  1  fetch strobe (one cycle, fetch state).
- `imem_data`  in  32  instruction word at `imem_addr`.
- `imem_valid`  in  1  `imem_data` valid this cycle.
- `imem_addr`  out  PC_W  equals `pc`.
- `imem_rd`  out  1  read request.
- `pc`  out  PC_W  program counter.
- `ir`  out  32  instruction register.
- `opcode`  out  4  `ir[31:28]`.
- `mm`  out  4  `ir[27:24]`.
- `imm`  out  16  `ir[15:0]`.
- `fetch_stall`  out  1  high while in WAIT.
- `fetch_err`  out  1  sticky wait-timeout flag.
- `halted`  out  1  HLT fetched; fetching frozen.

## Operation
- States: RUN, WAIT, HALT. Reset state RUN.
- Reset (`rst_f`=0 at edge): `pc`=0, `ir`=0, `fetch_stall`=0, `fetch_err`=0, `halted`=0, wait counter=0, pending-increment flag=0, state RUN. `imem_rd` is 0 throughout reset.
- Priority per edge: `rst_f` > `pc_rst` > state actions.
- `pc_rst`=1: `pc`←0; WAIT aborts to RUN; pending flag and counter cleared. IR, `fetch_err` and `halted` are unchanged. HALT is left only by `rst_f`.
- RUN, `ir_load`=1, `imem_valid`=1: `ir`←`imem_data`. If `pc_write`&!`pc_sel`, `pc`←`pc`+1.
- RUN, `ir_load`=1, `imem_valid`=0: go to WAIT, `pc` held, pending←`pc_write`&!`pc_sel`, counter←1.
- RUN, `pc_write`=1, `pc_sel`=1: `pc`←target. This applies even with `ir_load`; IR still loads per the rules above from the old `pc` address.
- Target: `br_sel`=1 → `imm[PC_W-1:0]`. `br_sel`=0 → `pc` + sign-extended `imm`, modulo 2^PC_W.
- PC+1 wraps 2^PC_W−1 → 0 silently.
- WAIT: `pc_write`/`ir_load` ignored.
  - On `imem_valid`: `ir`←`imem_data`, `pc`+1 if pending, go to RUN.
  - Else if counter = WAIT_LIMIT: `ir`←0 (NOOP), `fetch_err`←1, `pc`+1 if pending, go to RUN.
  - Else counter+1.
- HLT detect: any IR load with `imem_data[31:28]`=15 goes to HALT, `halted`←1. In HALT, `pc` and `ir` are frozen and all strobes except `pc_rst` are ignored.
- `imem_rd` = (RUN & `ir_load`) | WAIT; combinational.

## Timing
- `opcode`/`mm`/`imm` are valid the cycle after an IR load edge. With `imem_valid` same-cycle, the load happens on the `ir_load` edge, so ctrl decode sees the new IR with zero added latency.
- Each memory wait cycle adds one stall cycle. `fetch_stall` is registered: it rises the cycle after a missed `ir_load` and falls on the edge that loads IR.
- Timeout: RUN→WAIT edge, then WAIT_LIMIT further edges; IR←0 on the last.
- `halted` rises on the same edge the HLT word enters IR.

## Configuration
- `FETCH_HALT_EN` defined: HLT detection and HALT state as above.
- Not defined: opcode 15 loads as an ordinary instruction, `halted` is tied 0, and no HALT state exists.

## Test plan
- Reset then fetch: `rst_f`=0 one edge; `ir_load`+`pc_write`, `imem_valid`=1, data 0x81230000 → `ir`=0x81230000, `opcode`=8, `mm`=1, `pc`=1.
- Branches: `pc`=0x0010, `imm`=0xFFFC, `pc_write`,`pc_sel`=1,`br_sel`=0 → `pc`=0x000C. Same with `br_sel`=1 → `pc`=0xFFFC.
- Wait states: `imem_valid` low 3 cycles after `ir_load` → `fetch_stall` high 3 cycles, `imem_addr` stable; on valid, `ir` loads and `pc` +1 once.
- Timeout (WAIT_LIMIT=4): `imem_valid` never asserted → `ir`=0, `fetch_err`=1 (sticky), `pc` +1, state RUN.
- HLT (`FETCH_HALT_EN`): load 0xF0000000 → `halted`=1; subsequent `pc_write`/`ir_load` leave `pc`/`ir` unchanged. `pc_rst` clears `pc` only; `rst_f` clears `halted`.
- Wrap and mid-wait reset: `pc`=0xFFFF, increment → 0. `pc_rst` during WAIT → RUN, `pc`=0, `fetch_stall`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the SISC CPU.
// Holds the program counter and instruction register. Tolerates a
// variable-latency instruction memory through a valid handshake with a
// bounded wait, and reports a sticky timeout error.
// Optional feature macro: FETCH_HALT_EN enables HLT (opcode 15) detection
// and the HALT state. When the macro is undefined, opcode 15 loads as an
// ordinary instruction and `halted` stays 0.
module fetch_unit #(
   parameter int PC_W       = 16,
   parameter int WAIT_LIMIT = 15
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic            pc_rst,
   input  logic            pc_write,
   input  logic            pc_sel,
   input  logic            br_sel,
   input  logic            ir_load,
   input  logic [31:0]     imem_data,
   input  logic            imem_valid,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_rd,
   output logic [PC_W-1:0] pc,
   output logic [31:0]     ir,
   output logic [3:0]      opcode,
   output logic [3:0]      mm,
   output logic [15:0]     imm,
   output logic            fetch_stall,
   output logic            fetch_err,
   output logic            halted
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1
`ifdef FETCH_HALT_EN
      , ST_HALT = 2'd2
`endif
   } state_t;

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              stall_q, stall_d;
   logic              err_q, err_d;
   logic              halted_q, halted_d;

   logic [PC_W-1:0]   pc_inc_s;
   logic [PC_W-1:0]   target_s;
   logic              hlt_s;

   // A word entering IR is a halt request only when HALT support is built in.
   function automatic logic is_hlt(input logic [31:0] word);
`ifdef FETCH_HALT_EN
      return (word[31:28] == 4'hF);
`else
      return 1'b0;
`endif
   endfunction

   assign pc_inc_s = pc_q + PC_W'(1);
   assign target_s = br_sel ? PC_W'(ir_q[15:0])
                            : pc_q + PC_W'($signed(ir_q[15:0]));
   assign hlt_s    = is_hlt(imem_data);

   // Next-state logic: pc_rst outranks every state action; reset is applied in the flop block.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      err_d    = err_q;
      halted_d = halted_q;
      if (pc_rst) begin
         pc_d   = {PC_W{1'b0}};
         cnt_d  = 8'd0;
         pend_d = 1'b0;
         if (state_q == ST_WAIT) begin
            state_d = ST_RUN;
         end else begin
            state_d = state_q;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (ir_load && imem_valid) begin
                  ir_d = imem_data;
                  if (hlt_s) begin
                     state_d  = state_t'(2'd2);
                     halted_d = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else if (ir_load) begin
                  // Miss: hold the address and remember a deferred increment.
                  state_d = ST_WAIT;
                  pend_d  = pc_write && !pc_sel;
                  cnt_d   = 8'd1;
               end else begin
                  state_d = ST_RUN;
               end
               if (pc_write && pc_sel) begin
                  pc_d = target_s;
               end else if (pc_write && !(ir_load && !imem_valid)) begin
                  pc_d = pc_inc_s;
               end else begin
                  pc_d = pc_q;
               end
            end
            ST_WAIT: begin
               if (imem_valid) begin
                  ir_d   = imem_data;
                  pc_d   = pend_q ? pc_inc_s : pc_q;
                  pend_d = 1'b0;
                  cnt_d  = 8'd0;
                  if (hlt_s) begin
                     state_d  = state_t'(2'd2);
                     halted_d = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else if (cnt_q == LIMIT) begin
                  // Timeout: substitute a NOOP and flag the error.
                  ir_d    = 32'h0000_0000;
                  err_d   = 1'b1;
                  pc_d    = pend_q ? pc_inc_s : pc_q;
                  pend_d  = 1'b0;
                  cnt_d   = 8'd0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
`ifdef FETCH_HALT_EN
            ST_HALT: begin
               state_d = ST_HALT;
            end
`endif
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
      stall_d = (state_d == ST_WAIT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state_q  <= ST_RUN;
         pc_q     <= {PC_W{1'b0}};
         ir_q     <= 32'h0000_0000;
         cnt_q    <= 8'd0;
         pend_q   <= 1'b0;
         stall_q  <= 1'b0;
         err_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         stall_q  <= stall_d;
         err_q    <= err_d;
         halted_q <= halted_d;
      end
   end

   assign imem_rd     = rst_f && (((state_q == ST_RUN) && ir_load) || (state_q == ST_WAIT));
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign ir          = ir_q;
   assign opcode      = ir_q[31:28];
   assign mm          = ir_q[27:24];
   assign imm         = ir_q[15:0];
   assign fetch_stall = stall_q;
   assign fetch_err   = err_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit (WAIT_LIMIT overridden to 4).
module tb_fetch_unit;

`ifdef FETCH_HALT_EN
   localparam bit HE = 1'b1;
`else
   localparam bit HE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_valid;
   logic [31:0] imem_data;
   logic [15:0] imem_addr, pc, imm;
   logic        imem_rd, fetch_stall, fetch_err, halted;
   logic [31:0] ir;
   logic [3:0]  opcode, mm;

   int checks = 0;
   int failures = 0;

   fetch_unit #(.PC_W(16), .WAIT_LIMIT(4)) dut (
      .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
      .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
      .imem_data(imem_data), .imem_valid(imem_valid),
      .imem_addr(imem_addr), .imem_rd(imem_rd), .pc(pc), .ir(ir),
      .opcode(opcode), .mm(mm), .imm(imm), .fetch_stall(fetch_stall),
      .fetch_err(fetch_err), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  ctl;     // {rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_valid}
      logic [31:0] data;
      logic        exp_rd;
      logic [15:0] exp_pc;
      logic [31:0] exp_ir;
      logic        exp_stall;
      logic        exp_err;
      logic        exp_halt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [6:0] ctl, input logic [31:0] data, input logic rd,
                      input logic [15:0] epc, input logic [31:0] eir,
                      input logic st, input logic er, input logic ht);
      vec_t v;
      v.ctl = ctl; v.data = data; v.exp_rd = rd; v.exp_pc = epc; v.exp_ir = eir;
      v.exp_stall = st; v.exp_err = er; v.exp_halt = ht;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
      end
   endtask

   initial begin
      // ctl bits: rst_f pc_rst pw ps bs il iv
      add(7'b0_0_0_0_0_1_0, 32'h0,         1'b0, 16'h0000, 32'h0,         1'b0, 1'b0, 1'b0); // reset, rd gated
      add(7'b1_0_1_0_0_1_1, 32'h81230000,  1'b1, 16'h0001, 32'h81230000,  1'b0, 1'b0, 1'b0); // first fetch
      add(7'b1_0_0_0_0_1_1, 32'h10000010,  1'b1, 16'h0001, 32'h10000010,  1'b0, 1'b0, 1'b0); // load imm 0x10
      add(7'b1_0_1_1_1_0_0, 32'h0,         1'b0, 16'h0010, 32'h10000010,  1'b0, 1'b0, 1'b0); // abs branch
      add(7'b1_0_0_0_0_1_1, 32'h1000FFFC,  1'b1, 16'h0010, 32'h1000FFFC,  1'b0, 1'b0, 1'b0); // load imm -4
      add(7'b1_0_1_1_0_0_0, 32'h0,         1'b0, 16'h000C, 32'h1000FFFC,  1'b0, 1'b0, 1'b0); // rel branch
      add(7'b1_0_1_1_1_0_0, 32'h0,         1'b0, 16'hFFFC, 32'h1000FFFC,  1'b0, 1'b0, 1'b0); // abs 0xFFFC
      add(7'b1_0_1_0_0_1_0, 32'h0,         1'b1, 16'hFFFC, 32'h1000FFFC,  1'b1, 1'b0, 1'b0); // miss
      add(7'b1_0_0_0_0_0_0, 32'h0,         1'b1, 16'hFFFC, 32'h1000FFFC,  1'b1, 1'b0, 1'b0);
      add(7'b1_0_0_0_0_0_0, 32'h0,         1'b1, 16'hFFFC, 32'h1000FFFC,  1'b1, 1'b0, 1'b0);
      add(7'b1_0_0_0_0_0_1, 32'h2000FFFF,  1'b1, 16'hFFFD, 32'h2000FFFF,  1'b0, 1'b0, 1'b0); // late valid
      add(7'b1_0_1_1_1_0_0, 32'h0,         1'b0, 16'hFFFF, 32'h2000FFFF,  1'b0, 1'b0, 1'b0); // to 0xFFFF
      add(7'b1_0_1_0_0_1_1, 32'h30000005,  1'b1, 16'h0000, 32'h30000005,  1'b0, 1'b0, 1'b0); // wrap
      add(7'b1_0_1_0_0_1_0, 32'h0,         1'b1, 16'h0000, 32'h30000005,  1'b1, 1'b0, 1'b0); // miss
      add(7'b1_0_1_1_1_1_0, 32'h0,         1'b1, 16'h0000, 32'h30000005,  1'b1, 1'b0, 1'b0); // strobes ignored
      add(7'b1_0_0_0_0_0_0, 32'h0,         1'b1, 16'h0000, 32'h30000005,  1'b1, 1'b0, 1'b0);
      add(7'b1_0_0_0_0_0_0, 32'h0,         1'b1, 16'h0000, 32'h30000005,  1'b1, 1'b0, 1'b0);
      add(7'b1_0_0_0_0_0_0, 32'h0,         1'b1, 16'h0001, 32'h0,         1'b0, 1'b1, 1'b0); // timeout
      add(7'b1_0_1_0_0_1_1, 32'h40000000,  1'b1, 16'h0002, 32'h40000000,  1'b0, 1'b1, 1'b0); // err sticky
      add(7'b1_0_0_0_0_1_0, 32'h0,         1'b1, 16'h0002, 32'h40000000,  1'b1, 1'b1, 1'b0); // miss
      add(7'b1_1_0_0_0_0_0, 32'h0,         1'b1, 16'h0000, 32'h40000000,  1'b0, 1'b1, 1'b0); // pc_rst in WAIT
      add(7'b1_1_1_0_0_1_1, 32'h50000000,  1'b1, 16'h0000, 32'h40000000,  1'b0, 1'b1, 1'b0); // pc_rst wins
      add(7'b1_0_1_0_0_1_1, 32'hF0000000,  1'b1, 16'h0001, 32'hF0000000,  1'b0, 1'b1, HE);   // HLT word
      add(7'b1_0_1_0_0_1_1, 32'h60000000,  !HE,  HE ? 16'h0001 : 16'h0002,
          HE ? 32'hF0000000 : 32'h60000000, 1'b0, 1'b1, HE);
      add(7'b1_1_0_0_0_0_0, 32'h0,         1'b0, 16'h0000,
          HE ? 32'hF0000000 : 32'h60000000, 1'b0, 1'b1, HE);                                // pc_rst only pc
      add(7'b0_0_1_0_0_1_1, 32'h70000000,  1'b0, 16'h0000, 32'h0,         1'b0, 1'b0, 1'b0); // rst_f clears all

      {rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_valid} = 7'b0;
      imem_data = 32'h0;
      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         {rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_valid} = vecs[i].ctl;
         imem_data = vecs[i].data;
         #1;
         chk("imem_rd", i, 32'(imem_rd), 32'(vecs[i].exp_rd));
         @(posedge clk);
         #1;
         chk("pc",        i, 32'(pc),          32'(vecs[i].exp_pc));
         chk("imem_addr", i, 32'(imem_addr),   32'(vecs[i].exp_pc));
         chk("ir",        i, ir,               vecs[i].exp_ir);
         chk("opcode",    i, 32'(opcode),      32'(vecs[i].exp_ir[31:28]));
         chk("mm",        i, 32'(mm),          32'(vecs[i].exp_ir[27:24]));
         chk("imm",       i, 32'(imm),         32'(vecs[i].exp_ir[15:0]));
         chk("stall",     i, 32'(fetch_stall), 32'(vecs[i].exp_stall));
         chk("fetch_err", i, 32'(fetch_err),   32'(vecs[i].exp_err));
         chk("halted",    i, 32'(halted),      32'(vecs[i].exp_halt));
      end

      // Hand sequence: count stall cycles of a full timeout (expect WAIT_LIMIT = 4).
      begin
         int n;
         {rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_valid} = 7'b1_0_0_0_0_1_0;
         @(posedge clk);
         #1;
         ir_load = 1'b0;
         n = fetch_stall ? 1 : 0;
         while (fetch_stall && n < 20) begin
            @(posedge clk);
            #1;
            if (fetch_stall) n++;
         end
         chk("timeout_len", 100, 32'(n), 32'd4);
         chk("timeout_ir",  100, ir, 32'h0);
         chk("timeout_err", 100, 32'(fetch_err), 32'd1);
         chk("timeout_pc",  100, 32'(pc), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
